// File: rtl/ctrl_sequencer.sv
// Microcoded control sequencer: fetches a 16-bit instruction, then steps through
// its execute cycles, decoding strobes combinationally from state, step and IR.
module ctrl_sequencer #(
  parameter int DW       = 16,
  parameter int RW       = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in,
  input  logic [3:0]    flags,
  input  logic          mem_ready,
  input  logic          irq,
  output logic [3:0]    alu_opcode,
  output logic          alu_out_en,
  output logic          mem_addr_en,
  output logic          mem_out_en,
  output logic          reg_in_en,
  output logic          reg_out_en,
  output logic          reg_pc_inc,
  output logic          out_en,
  output logic [RW-1:0] reg_src_sel,
  output logic [RW-1:0] reg_dst_sel,
  output logic [DW-1:0] out,
  output logic [2:0]    step,
  output logic          halted,
  output logic          fault,
  output logic [1:0]    fault_cause
);

  localparam int WCW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);
  localparam logic [RW-1:0]  TMP       = '1;
  localparam logic [RW-1:0]  PC        = '0;

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  state_t         state;
  logic [15:0]    ir;
  logic           br_taken;
  logic [WCW-1:0] wait_cnt;

  logic [3:0]    opcode;
  logic [RW-1:0] dst, src, ld_dst;
  logic          imm, ind, cond, taken, ld_like, is_alu, is_illegal, is_hlt;
  logic          bus_wait, last;

  assign opcode     = ir[15:12];
  assign dst        = RW'(ir[11:9]);
  assign src        = RW'(ir[6:4]);
  assign imm        = ir[8];
  assign ind        = ir[7];
  assign is_alu     = (opcode >= 4'd3) && (opcode <= 4'd9);
  assign is_illegal = opcode inside {4'd2, 4'd10, 4'd11, 4'd13, 4'd14};
  assign is_hlt     = (opcode == 4'd0) && (ir[11:8] == 4'hF);

  always_comb begin
    case (ir[11:9])
      3'd0:    cond = flags[3];
      3'd1:    cond = ~flags[3];
      3'd2:    cond = flags[2];
      3'd3:    cond = ~flags[2];
      3'd4:    cond = flags[1];
      3'd5:    cond = ~flags[1];
      3'd6:    cond = flags[0];
      default: cond = ~flags[0];
    endcase
  end

  // A branch decides on live flags in step2; later steps use the value latched then.
  assign taken   = (step == 3'd2) ? cond : br_taken;
  assign ld_like = (opcode == 4'd1) || ((opcode == 4'd15) && taken);
  assign ld_dst  = (opcode == 4'd15) ? PC : dst;

  // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    alu_opcode  = '0;
    alu_out_en  = 1'b0;
    mem_addr_en = 1'b0;
    mem_out_en  = 1'b0;
    reg_in_en   = 1'b0;
    reg_out_en  = 1'b0;
    reg_pc_inc  = 1'b0;
    out_en      = 1'b0;
    reg_src_sel = '0;
    reg_dst_sel = '0;
    out         = '0;
    last        = 1'b1;
    case (state)
      FETCH: begin
        if (step == 3'd0) begin
          reg_src_sel = PC;
          reg_out_en  = 1'b1;
          mem_addr_en = 1'b1;
        end else begin
          mem_out_en = 1'b1;
          reg_pc_inc = mem_ready;
        end
      end
      EXEC: begin
        if (ld_like) begin
          if (imm) begin
            out_en      = 1'b1;
            out         = DW'(ir[7:0]);
            reg_dst_sel = ld_dst;
            reg_in_en   = 1'b1;
          end else if (!ind) begin
            reg_src_sel = src;
            reg_dst_sel = ld_dst;
            reg_out_en  = 1'b1;
            reg_in_en   = 1'b1;
          end else if (step == 3'd2) begin
            reg_src_sel = src;
            reg_out_en  = 1'b1;
            mem_addr_en = 1'b1;
            last        = 1'b0;
          end else begin
            mem_out_en  = 1'b1;
            reg_dst_sel = ld_dst;
            reg_in_en   = mem_ready;
          end
        end else if (is_alu) begin
          if (imm && step == 3'd2) begin
            out_en      = 1'b1;
            out         = DW'(ir[7:0]);
            reg_dst_sel = TMP;
            reg_in_en   = 1'b1;
            last        = 1'b0;
          end else if (!imm && ind && step == 3'd2) begin
            reg_src_sel = src;
            reg_out_en  = 1'b1;
            mem_addr_en = 1'b1;
            last        = 1'b0;
          end else if (!imm && ind && step == 3'd3) begin
            mem_out_en  = 1'b1;
            reg_dst_sel = TMP;
            reg_in_en   = mem_ready;
            last        = 1'b0;
          end else begin
            alu_opcode  = opcode;
            reg_src_sel = (imm || ind) ? TMP : src;
            reg_dst_sel = dst;
            alu_out_en  = 1'b1;
            reg_in_en   = 1'b1;
          end
        end else if (opcode == 4'd12) begin
          out_en      = 1'b1;
          out         = DW'(ir[11:0]);
          reg_dst_sel = PC;
          reg_in_en   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign halted   = (state == HALT);
  assign bus_wait = mem_out_en && !mem_ready;

  // NOTE: sequential state uses non-blocking assignments; later ones in the block win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      step        <= '0;
      ir          <= '0;
      br_taken    <= 1'b0;
      wait_cnt    <= '0;
      fault       <= 1'b0;
      fault_cause <= '0;
    end else begin
      wait_cnt <= '0;
      if (bus_wait) begin
        if (wait_cnt == WAIT_LAST) begin
          state       <= HALT;
          step        <= '0;
          fault       <= 1'b1;
          fault_cause <= 2'b10;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else begin
        case (state)
          FETCH: begin
            if (step == 3'd0) begin
              step <= 3'd1;
            end else begin
              ir    <= in[15:0];
              state <= EXEC;
              step  <= 3'd2;
            end
          end
          EXEC: begin
            if (step == 3'd2) br_taken <= cond;
            if (step == 3'd2 && is_illegal) begin
              state       <= HALT;
              step        <= '0;
              fault       <= 1'b1;
              fault_cause <= 2'b01;
            end else if (step == 3'd2 && is_hlt) begin
              state <= HALT;
              step  <= '0;
            end else if (last) begin
              state <= FETCH;
              step  <= '0;
            end else begin
              step <= step + 3'd1;
            end
          end
          HALT: begin
            if (irq && !fault) begin
              state <= FETCH;
              step  <= '0;
            end
          end
          default: begin
            state <= FETCH;
            step  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: each instruction is expanded into micro-operations
// from the instruction rules, and every cycle's outputs are compared to them.
module tb_ctrl_sequencer;

  localparam int DW       = 16;
  localparam int RW       = 3;
  localparam int WAIT_MAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in;
  logic [3:0]    flags;
  logic          mem_ready;
  logic          irq;
  logic [3:0]    alu_opcode;
  logic          alu_out_en, mem_addr_en, mem_out_en, reg_in_en;
  logic          reg_out_en, reg_pc_inc, out_en;
  logic [RW-1:0] reg_src_sel, reg_dst_sel;
  logic [DW-1:0] out;
  logic [2:0]    step;
  logic          halted, fault;
  logic [1:0]    fault_cause;

  ctrl_sequencer #(.DW(DW), .RW(RW), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .in(in), .flags(flags), .mem_ready(mem_ready), .irq(irq),
    .alu_opcode(alu_opcode), .alu_out_en(alu_out_en), .mem_addr_en(mem_addr_en),
    .mem_out_en(mem_out_en), .reg_in_en(reg_in_en), .reg_out_en(reg_out_en),
    .reg_pc_inc(reg_pc_inc), .out_en(out_en), .reg_src_sel(reg_src_sel),
    .reg_dst_sel(reg_dst_sel), .out(out), .step(step), .halted(halted),
    .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    op;
    logic          alu_en, addr_en, mout_en, rin_en, rout_en, pc_inc, oen;
    logic [2:0]    src, dst;
    logic [15:0]   data;
    logic [2:0]    step;
    logic          halted, fault;
    logic [1:0]    cause;
  } vec_t;

  typedef enum {U_NONE, U_LOAD_VAL, U_LOAD_IR12, U_MOVE, U_ADDR, U_READ, U_ALU} uop_kind_t;
  typedef struct {
    uop_kind_t  kind;
    logic [2:0] src;
    logic [2:0] dst;
    logic [3:0] op;
  } uop_t;
  typedef enum {END_FETCH, END_HALT, END_FAULT} end_t;

  uop_t plan[$];
  end_t plan_end;
  int   checks = 0;
  int   errors = 0;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [15:0] r16();
    return 16'($urandom);
  endfunction
  function automatic logic [3:0] r4();
    return 4'($urandom);
  endfunction

  function automatic vec_t observed();
    vec_t v;
    v.op = alu_opcode;     v.alu_en = alu_out_en;  v.addr_en = mem_addr_en;
    v.mout_en = mem_out_en; v.rin_en = reg_in_en;   v.rout_en = reg_out_en;
    v.pc_inc = reg_pc_inc; v.oen = out_en;         v.src = reg_src_sel;
    v.dst = reg_dst_sel;   v.data = out;           v.step = step;
    v.halted = halted;     v.fault = fault;        v.cause = fault_cause;
    return v;
  endfunction

  task automatic check(input string tag, input vec_t exp_v, input bit ignore_step);
    vec_t obs;
    obs = observed();
    if (ignore_step) begin
      obs.step   = '0;
      exp_v.step = '0;
    end
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input vec_t exp_v, input logic mr, input logic [15:0] din,
                     input logic [3:0] fl, input logic rq, input bit ign, input string tag);
    mem_ready = mr;
    in        = din;
    flags     = fl;
    irq       = rq;
    @(negedge clk);
    check(tag, exp_v, ign);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t v_fetch0();
    vec_t v = '0;
    v.rout_en = 1'b1;
    v.addr_en = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_fetch1(input logic mr);
    vec_t v = '0;
    v.mout_en = 1'b1;
    v.pc_inc  = mr;
    v.step    = 3'd1;
    return v;
  endfunction

  function automatic vec_t v_halt(input logic f, input logic [1:0] c);
    vec_t v = '0;
    v.halted = 1'b1;
    v.fault  = f;
    v.cause  = c;
    return v;
  endfunction

  function automatic vec_t v_uop(input uop_t u, input logic [15:0] instr, input logic mr, input int idx);
    vec_t v = '0;
    v.step = 3'(2 + idx);
    case (u.kind)
      U_LOAD_VAL:  begin v.oen = 1; v.data = {8'h00, instr[7:0]}; v.dst = u.dst; v.rin_en = 1; end
      U_LOAD_IR12: begin v.oen = 1; v.data = {4'h0, instr[11:0]}; v.dst = 3'd0; v.rin_en = 1; end
      U_MOVE:      begin v.src = u.src; v.dst = u.dst; v.rout_en = 1; v.rin_en = 1; end
      U_ADDR:      begin v.src = u.src; v.rout_en = 1; v.addr_en = 1; end
      U_READ:      begin v.mout_en = 1; v.dst = u.dst; v.rin_en = mr; end
      U_ALU:       begin v.op = u.op; v.src = u.src; v.dst = u.dst; v.alu_en = 1; v.rin_en = 1; end
      default: ;
    endcase
    return v;
  endfunction

  function automatic uop_t mk(input uop_kind_t k, input logic [2:0] s, input logic [2:0] d, input logic [3:0] op);
    uop_t u;
    u.kind = k; u.src = s; u.dst = d; u.op = op;
    return u;
  endfunction

  task automatic add_load(input logic [2:0] d, input logic [2:0] s, input logic im, input logic id);
    if (im) plan.push_back(mk(U_LOAD_VAL, 3'd0, d, 4'd0));
    else if (id) begin
      plan.push_back(mk(U_ADDR, s, 3'd0, 4'd0));
      plan.push_back(mk(U_READ, 3'd0, d, 4'd0));
    end else plan.push_back(mk(U_MOVE, s, d, 4'd0));
  endtask

  // Expand an instruction into its execute-phase micro-operations.
  task automatic plan_instr(input logic [15:0] instr, input logic [3:0] flg);
    logic [3:0] opc;
    logic [2:0] d, s;
    logic       im, id, tk;
    int         fidx;
    opc = instr[15:12]; d = instr[11:9]; s = instr[6:4]; im = instr[8]; id = instr[7];
    plan.delete();
    plan_end = END_FETCH;
    if (opc == 4'd0) begin
      plan.push_back(mk(U_NONE, 3'd0, 3'd0, 4'd0));
      if (instr[11:8] == 4'hF) plan_end = END_HALT;
    end else if (opc == 4'd1) begin
      add_load(d, s, im, id);
    end else if (opc >= 4'd3 && opc <= 4'd9) begin
      if (im) begin
        plan.push_back(mk(U_LOAD_VAL, 3'd0, 3'd7, 4'd0));
        plan.push_back(mk(U_ALU, 3'd7, d, opc));
      end else if (id) begin
        plan.push_back(mk(U_ADDR, s, 3'd0, 4'd0));
        plan.push_back(mk(U_READ, 3'd0, 3'd7, 4'd0));
        plan.push_back(mk(U_ALU, 3'd7, d, opc));
      end else plan.push_back(mk(U_ALU, s, d, opc));
    end else if (opc == 4'd12) begin
      plan.push_back(mk(U_LOAD_IR12, 3'd0, 3'd0, 4'd0));
    end else if (opc == 4'd15) begin
      fidx = 3 - (int'(d) >> 1);
      tk = flg[fidx] ^ d[0];
      if (tk) add_load(3'd0, s, im, id);
      else plan.push_back(mk(U_NONE, 3'd0, 3'd0, 4'd0));
    end else begin
      plan.push_back(mk(U_NONE, 3'd0, 3'd0, 4'd0));
      plan_end = END_FAULT;
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, ":rst_now"}, v_fetch0(), 1'b0);
    @(posedge clk);
    #1;
    check({tag, ":rst_hold"}, v_fetch0(), 1'b0);
    rst = 1'b0;
  endtask

  task automatic fault_tail(input logic [1:0] cause, input string tag);
    repeat (3) cyc(v_halt(1'b1, cause), rbit(), r16(), r4(), 1'b1, 1'b1, {tag, ":fault"});
    do_reset(tag);
  endtask

  task automatic run_instr(input logic [15:0] instr, input logic [3:0] flg, input int fwait,
                           input int rwait, input int abort_step, input string tag);
    logic [3:0] fl;
    logic       mr;
    cyc(v_fetch0(), rbit(), r16(), r4(), rbit(), 1'b0, {tag, ":f0"});
    for (int w = 0; w < fwait; w++) begin
      cyc(v_fetch1(1'b0), 1'b0, r16(), r4(), rbit(), 1'b0, {tag, ":fwait"});
      if (w + 1 == WAIT_MAX) begin
        fault_tail(2'b10, tag);
        return;
      end
    end
    cyc(v_fetch1(1'b1), 1'b1, instr, r4(), rbit(), 1'b0, {tag, ":f1"});
    plan_instr(instr, flg);
    foreach (plan[i]) begin
      if (2 + i == abort_step) begin
        do_reset(tag);
        return;
      end
      fl = (i == 0) ? flg : r4();
      if (plan[i].kind == U_READ) begin
        for (int w = 0; w < rwait; w++) begin
          cyc(v_uop(plan[i], instr, 1'b0, i), 1'b0, r16(), fl, rbit(), 1'b0, {tag, ":rwait"});
          if (w + 1 == WAIT_MAX) begin
            fault_tail(2'b10, tag);
            return;
          end
        end
        cyc(v_uop(plan[i], instr, 1'b1, i), 1'b1, r16(), fl, rbit(), 1'b0, {tag, ":read"});
      end else begin
        mr = rbit();
        cyc(v_uop(plan[i], instr, mr, i), mr, r16(), fl, rbit(), 1'b0, {tag, ":exec"});
      end
    end
    case (plan_end)
      END_HALT: begin
        repeat (2) cyc(v_halt(1'b0, 2'b00), rbit(), r16(), r4(), 1'b0, 1'b1, {tag, ":halt"});
        cyc(v_halt(1'b0, 2'b00), rbit(), r16(), r4(), 1'b1, 1'b1, {tag, ":wake"});
      end
      END_FAULT: fault_tail(2'b01, tag);
      default: ;
    endcase
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; in = 16'hFFFF; flags = 4'hF; irq = 1'b1;
    @(posedge clk);
    #1;
    check("reset", v_fetch0(), 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(16'h1305, 4'h0, 0, 0, -1, "ld_imm");
    run_instr(16'h3290, 4'h0, 0, 3, -1, "add_ind");
    run_instr(16'hF3A5, 4'b1000, 0, 0, -1, "br_not_taken");
    run_instr(16'hF3A5, 4'b0000, 0, 0, -1, "br_taken");
    run_instr(16'hF4B0, 4'b0100, 1, 2, -1, "br_ind_taken");
    run_instr(16'h0F00, 4'h0, 0, 0, -1, "hlt");
    run_instr(16'h0300, 4'h0, 0, 0, -1, "nop");
    run_instr(16'hC123, 4'h0, 2, 0, -1, "jmp");
    run_instr(16'h5A30, 4'h0, 0, 0, -1, "alu_reg");
    run_instr(16'h1490, 4'h0, 0, WAIT_MAX - 1, -1, "ld_ind_wait_edge");
    run_instr(16'h2000, 4'h0, 0, 0, -1, "illegal");
    run_instr(16'h1305, 4'h0, WAIT_MAX, 0, -1, "fetch_timeout");
    run_instr(16'h1490, 4'h0, 0, WAIT_MAX, -1, "read_timeout");
    run_instr(16'h3305, 4'h0, 0, 0, 3, "rst_in_alu");
    run_instr(16'h1305, 4'h0, 0, 0, -1, "after_rst");

    repeat (300) begin
      run_instr(r16(), r4(), $urandom_range(0, 3), $urandom_range(0, 3), -1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
